regfile_operand_reader: RTL
===========================

Name: regfile_operand_reader

Overview:
- Read side of the CPU's general-purpose register file: holds NUM_REGS x DATA_W storage and accepts one write per cycle from writeback.
- Serves two-operand read requests through a valid/ready handshake, with a registered 1-cycle response.
- Forwards a same-cycle writeback so decode always sees the newest value.
- Sits between the decode stage (requester) and the execute stage (response consumer).

Parameters:
- DATA_W, 32, register width in bits.
- NUM_REGS, 32, number of architectural registers.
- ADDR_W, 5, register index width; must satisfy 2^ADDR_W >= NUM_REGS.
- ZERO_REG, 1, when 1 register 0 is hardwired to zero.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- wr_en  input  1  writeback write strobe.
- wr_addr  input  ADDR_W  writeback register index.
- wr_data  input  DATA_W  writeback value.
- req_valid  input  1  decode presents a read request.
- req_ready  output  1  block can accept a request this cycle.
- req_rs1  input  ADDR_W  source operand 1 index.
- req_rs2  input  ADDR_W  source operand 2 index.
- req_tag  input  8  opaque request tag, returned with the response.
- rsp_valid  output  1  response holds valid operands.
- rsp_ready  input  1  execute consumes the response.
- rsp_rs1_data  output  DATA_W  operand 1 value.
- rsp_rs2_data  output  DATA_W  operand 2 value.
- rsp_tag  output  8  tag of the request being answered.

Behaviour:
- Reset (reset=0, asynchronous): all storage = 0; rsp_valid=0; rsp_rs1_data=0, rsp_rs2_data=0, rsp_tag=0. req_ready = 1 once reset deasserts.
- Write: on a rising edge with wr_en=1, storage[wr_addr] <= wr_data.
  - Ignored when ZERO_REG=1 and wr_addr=0.
  - Ignored when wr_addr >= NUM_REGS.
  - Writes are independent of the handshake state.
- Accept: a request is accepted when req_valid && req_ready at a rising edge.
- Ready rule (combinational): req_ready = !rsp_valid || rsp_ready.
  - Gives full throughput of one request per cycle with back-to-back acceptance.
  - There is no combinational path from req_valid to req_ready.
- Latency: operands and tag appear on rsp_* on the edge that accepts the request; rsp_valid=1 from that edge onward. This is 1 cycle after presentation.
- Operand value for each source rsN, evaluated in the accept cycle:
  - 0 if ZERO_REG=1 and rsN=0;
  - else 0 if rsN >= NUM_REGS;
  - else wr_data if wr_en=1 and wr_addr=rsN (same-cycle bypass, subject to the zero-register rule);
  - else storage[rsN].
- rs1=rs2 is legal; both outputs then return the same value.
- Stall: while rsp_valid=1 and rsp_ready=0, all rsp_* outputs hold stable.
  - Held operands are a snapshot taken at accept time.
  - Later writes to the same index do NOT alter a held response; hazard handling is the pipeline's job.
- Drain: rsp_valid=1, rsp_ready=1, req_valid=0 at an edge -> rsp_valid=0. rsp data and tag keep their last values, which are don't-care.
- Replace: rsp_valid=1, rsp_ready=1, req_valid=1 at an edge -> the new response is loaded and rsp_valid stays 1.
- Requester rule: no ordering restriction, but req_rs1, req_rs2 and req_tag must be held stable while req_valid=1 and req_ready=0.
- Reset mid-operation: any pending response is dropped (rsp_valid -> 0 immediately) and storage is cleared.
- State: one response register (rsp_valid plus payload) and the storage array. No other FSM.

Test Plan:
- Reset then read: assert reset=0 for 3 cycles, release, request rs1=5, rs2=31 -> next edge rsp_valid=1, both data=0x00000000, tag echoed.
- Write then read: write r7=0xDEADBEEF, next cycle request rs1=7, rs2=0 -> rsp_rs1_data=0xDEADBEEF, rsp_rs2_data=0.
- Same-cycle bypass: in the same cycle, write r3=0x12345678 and request rs1=3, rs2=3 -> both outputs 0x12345678. Also write r0=0xFFFFFFFF with rs1=0 -> output 0.
- Backpressure: hold rsp_ready=0 for 4 cycles after an accept, and write the read register during the stall -> req_ready=0 and rsp_* stable at the pre-write value. On rsp_ready=1, a queued request (tag 0x2A) is accepted the same edge.
- Throughput: rsp_ready=1, 8 consecutive requests with tags 0..7 -> 8 responses on 8 consecutive edges in order, with correct data.
- Reset mid-stall: rsp_valid=1 with rsp_ready=0, assert reset -> rsp_valid falls immediately. After release, a read of the previously written register returns 0.

Source files
------------

// File: rtl/regfile_operand_reader.sv
// rtl/regfile_operand_reader.sv - register file with a two-operand read port and writeback bypass
// One registered response slot; operands are snapshotted when a request is accepted.
module regfile_operand_reader #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs1,
  input  logic [ADDR_W-1:0] req_rs2,
  input  logic [7:0]        req_tag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs1_data,
  output logic [DATA_W-1:0] rsp_rs2_data,
  output logic [7:0]        rsp_tag
);

  localparam logic [ADDR_W:0] NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_hit;
  logic              accept;
  logic [DATA_W-1:0] rs1_val;
  logic [DATA_W-1:0] rs2_val;

  function automatic logic in_range(input logic [ADDR_W-1:0] idx);
    return ({1'b0, idx} < NUM_REGS_W);
  endfunction

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] idx);
    return (ZERO_REG != 0) && (idx == '0);
  endfunction

  // Newest value for an index: the writeback in flight this cycle wins over storage.
  function automatic logic [DATA_W-1:0] read_operand(input logic [ADDR_W-1:0] rs);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (rs == i[ADDR_W-1:0]) v = regs[i];
    end
    if (wr_hit && (wr_addr == rs)) v = wr_data;
    if (is_zero_reg(rs) || !in_range(rs)) v = '0;
    return v;
  endfunction

  assign wr_hit    = wr_en && in_range(wr_addr) && !is_zero_reg(wr_addr);
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  always_comb begin
    rs1_val = read_operand(req_rs1);
    rs2_val = read_operand(req_rs2);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_hit) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_addr == i[ADDR_W-1:0]) regs[i] <= wr_data;
      end
    end
  end

  // Payload only moves on accept, so a stalled or drained response keeps its last contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid    <= 1'b0;
      rsp_rs1_data <= '0;
      rsp_rs2_data <= '0;
      rsp_tag      <= '0;
    end else if (accept) begin
      rsp_valid    <= 1'b1;
      rsp_rs1_data <= rs1_val;
      rsp_rs2_data <= rs2_val;
      rsp_tag      <= req_tag;
    end else if (rsp_ready) begin
      rsp_valid    <= 1'b0;
    end
  end

endmodule
